// File: rtl/opaque_read_fifo.sv
// Depth-buffered opaque read port: a producer pushes N-bit words into a DEPTH-entry
// FIFO, and the CPU drains it over a shared bus with alternating status/data reads.
module opaque_read_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [N-1:0]  Din,
    input  logic          Din_arrived,
    output logic          Din_ready,
    inout  wire  [N-1:0]  io,
    input  logic          ena,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef enum logic [0:0] {
        ST_STATUS = 1'b0,
        ST_DATA   = 1'b1
    } phase_e;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    phase_e        phase_q, phase_d;

    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;
    logic          ovf_clr_s;
    logic [N-1:0]  status_s;
    logic [N-1:0]  bus_val_s;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room.
    assign full_s = (count_q == FULL_CNT);
    assign push_s = Din_arrived && !full_s;
    assign drop_s = Din_arrived && full_s;

    // Phase state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase_q <= ST_STATUS;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase next-state: every ena edge is one access; DATA is entered only when non-empty.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            ST_STATUS: begin
                if (ena && (count_q != '0)) begin
                    phase_d = ST_DATA;
                end else begin
                    phase_d = ST_STATUS;
                end
            end
            ST_DATA: begin
                if (ena) begin
                    phase_d = ST_STATUS;
                end else begin
                    phase_d = ST_DATA;
                end
            end
            default: phase_d = ST_STATUS;
        endcase
    end

    // Phase outputs: pop strobe, overflow-clear strobe and the word offered to the bus.
    always_comb begin
        pop_s     = 1'b0;
        ovf_clr_s = 1'b0;
        bus_val_s = status_s;
        case (phase_q)
            ST_STATUS: begin
                ovf_clr_s = ena;
                bus_val_s = status_s;
            end
            ST_DATA: begin
                pop_s     = ena;
                bus_val_s = mem_q[rd_ptr_q];
            end
            default: begin
                pop_s     = 1'b0;
                ovf_clr_s = 1'b0;
                bus_val_s = status_s;
            end
        endcase
    end

    // Status word: non-empty flag, sticky overflow, occupancy in the low bits.
    always_comb begin
        status_s         = '0;
        status_s[N-1]    = (count_q != '0);
        status_s[N-2]    = ovf_q;
        status_s[AW:0]   = count_q;
    end

    // Pointer, occupancy and overflow next-state; a dropped push outranks a clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write; contents are left untouched by reset.
    always_ff @(posedge Clock) begin
        if (!Reset && push_s) begin
            mem_q[wr_ptr_q] <= Din;
        end
    end

    assign Din_ready = !full_s;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign io        = ena ? {N{1'bz}} : bus_val_s;

endmodule

// File: tb/tb_opaque_read_fifo.sv
// Directed bench for opaque_read_fifo: stimulus queues expectations, a negedge monitor checks them.
module tb_opaque_read_fifo;

    localparam int N = 8;
    localparam int DEPTH = 4;
    localparam int AW = 2;

    localparam int K_IO  = 0;
    localparam int K_RDY = 1;
    localparam int K_CNT = 2;
    localparam int K_OVF = 3;

    typedef struct {
        string      name;
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [N-1:0]  Din = 8'h00;
    logic          Din_arrived = 1'b0;
    logic          ena = 1'b0;
    logic          Din_ready;
    logic [AW:0]   count;
    logic          overflow;
    wire  [N-1:0]  io;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    opaque_read_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Din         (Din),
        .Din_arrived (Din_arrived),
        .Din_ready   (Din_ready),
        .io          (io),
        .ena         (ena),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 Clock = ~Clock;

    // Monitor: compare every pending expectation against the settled DUT outputs.
    always @(negedge Clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_IO:    act = io;
                K_RDY:   act = {7'd0, Din_ready};
                K_CNT:   act = {5'd0, count};
                default: act = {7'd0, overflow};
            endcase
            n_checks++;
            if (act === e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
            end
        end
    end

    // Apply one clock edge with the given inputs, then return to idle just after it.
    task automatic drive(input logic arr, input logic [7:0] d, input logic en);
        Din_arrived = arr;
        Din         = d;
        ena         = en;
        @(posedge Clock);
        #1;
        Din_arrived = 1'b0;
        ena         = 1'b0;
    endtask

    task automatic expect_v(input string name, input int kind, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Let the monitor consume queued expectations at the next negedge.
    task automatic settle();
        @(negedge Clock);
        #1;
    endtask

    task automatic exp_io(input string name, input logic [7:0] val);
        expect_v(name, K_IO, val);
        settle();
    endtask

    initial begin
        // 1: reset and idle
        Reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        Reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        expect_v("rst_io", K_IO, 8'h00);
        expect_v("rst_rdy", K_RDY, 8'h01);
        expect_v("rst_cnt", K_CNT, 8'h00);
        expect_v("rst_ovf", K_OVF, 8'h00);
        settle();
        drive(1'b0, 8'h00, 1'b1);
        exp_io("empty_ena_status", 8'h00);

        // 2: single word round trip
        drive(1'b1, 8'hA5, 1'b0);
        expect_v("one_cnt", K_CNT, 8'h01);
        exp_io("one_status", 8'h81);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("one_data", 8'hA5);
        drive(1'b0, 8'h00, 1'b1);
        expect_v("one_cnt0", K_CNT, 8'h00);
        exp_io("one_empty", 8'h00);

        // 3: fill, overflow, drain
        drive(1'b1, 8'h01, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        drive(1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'h04, 1'b0);
        expect_v("full_rdy", K_RDY, 8'h00);
        settle();
        drive(1'b1, 8'h05, 1'b0);
        expect_v("ovf_cnt", K_CNT, 8'h04);
        expect_v("ovf_flag", K_OVF, 8'h01);
        exp_io("ovf_status", 8'hC4);
        drive(1'b0, 8'h00, 1'b1);
        expect_v("ovf_cleared", K_OVF, 8'h00);
        exp_io("fill_d1", 8'h01);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("fill_s1", 8'h83);
        for (int i = 2; i <= 4; i++) begin
            logic [7:0] w;
            logic [7:0] s;
            w = 8'(i);
            s = (i == 4) ? 8'h00 : (8'h80 | 8'(4 - i));
            drive(1'b0, 8'h00, 1'b1);
            exp_io("fill_data", w);
            drive(1'b0, 8'h00, 1'b1);
            exp_io("fill_status", s);
        end

        // 4: simultaneous push/pop in DATA with pointer wrap
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("pp_head", 8'h11);
        drive(1'b1, 8'h44, 1'b1);
        expect_v("pp_cnt", K_CNT, 8'h03);
        exp_io("pp_status", 8'h83);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("pp_d22", 8'h22);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("pp_s2", 8'h82);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("pp_d33", 8'h33);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("pp_s1", 8'h81);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("pp_d44_wrap", 8'h44);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("pp_s0", 8'h00);

        // 5: full in DATA, push dropped while pop happens
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h66, 1'b0);
        drive(1'b1, 8'h77, 1'b0);
        drive(1'b1, 8'h88, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("fp_head", 8'h55);
        drive(1'b1, 8'h99, 1'b1);
        expect_v("fp_cnt", K_CNT, 8'h03);
        expect_v("fp_ovf", K_OVF, 8'h01);
        exp_io("fp_status", 8'hC3);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("fp_d66", 8'h66);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("fp_s2", 8'h82);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("fp_d77", 8'h77);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("fp_s1", 8'h81);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("fp_d88", 8'h88);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("fp_s0", 8'h00);

        // Overflow set and clear on the same edge: set wins
        drive(1'b1, 8'hA1, 1'b0);
        drive(1'b1, 8'hA2, 1'b0);
        drive(1'b1, 8'hA3, 1'b0);
        drive(1'b1, 8'hA4, 1'b0);
        drive(1'b1, 8'hFF, 1'b1);
        expect_v("setclr_ovf", K_OVF, 8'h01);
        exp_io("setclr_head", 8'hA1);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("setclr_status", 8'hC3);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("setclr_dA2", 8'hA2);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("mid_head", 8'hA3);

        // 6: reset mid-transfer discards queue and phase
        Reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        Reset = 1'b0;
        expect_v("mrst_cnt", K_CNT, 8'h00);
        expect_v("mrst_ovf", K_OVF, 8'h00);
        expect_v("mrst_rdy", K_RDY, 8'h01);
        exp_io("mrst_status", 8'h00);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("mrst_ena_status", 8'h00);
        drive(1'b1, 8'h5A, 1'b0);
        exp_io("mrst_push_status", 8'h81);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("mrst_data", 8'h5A);
        drive(1'b0, 8'h00, 1'b1);
        exp_io("mrst_empty", 8'h00);

        settle();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL pending: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/opaque_read_fifo.md
Name: opaque_read_fifo

Overview:
Parametrised, depth-buffered successor to the single-entry opaque read port. It queues N-bit words from a producer (Din/Din_arrived) into a DEPTH-entry FIFO. The CPU reads it over the shared inout bus using a two-phase status/data protocol. Adds back-pressure, an occupancy count and a sticky overflow flag, all visible in the status word.

Parameters:
N, 8, data/bus width; must satisfy N >= AW+3
DEPTH, 4, FIFO entries; power of two, >= 2
AW, 2, pointer width, = log2(DEPTH)

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Din  input  N  producer data
Din_arrived  input  1  producer push strobe, one word per cycle while high
Din_ready  output  1  FIFO not full (count < DEPTH), combinational from state
io  inout  N  shared CPU bus
ena  input  1  CPU access strobe; while high, block tri-states io
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky flag: a push was dropped

Behaviour:
- Reset, sampled at posedge while high, clears:
  - rd_ptr, wr_ptr and count to 0
  - reading to 0 and overflow to 0
  - storage contents need not be cleared
  - after reset: Din_ready=1, count=0, overflow=0, io drives all-zero status
- Reset mid-transfer: the queue and phase are discarded; no pop completes.
- io drive:
  - ena=1: io = high-Z.
  - ena=0 and reading=1 (DATA phase): io = mem[rd_ptr], the head word.
  - ena=0 and reading=0 (STATUS phase): io = status word.
    - bit N-1 = (count != 0)
    - bit N-2 = overflow
    - bits AW:0 = count
    - all other bits 0
- Push, evaluated at each posedge:
  - Din_arrived=1 and count<DEPTH: mem[wr_ptr] <= Din, wr_ptr increments mod DEPTH.
  - Din_arrived=1 and count==DEPTH: word dropped, overflow <= 1.
  - Full is judged on pre-edge count. A push while full is dropped even if a pop occurs in the same cycle.
- Phase machine (reading):
  - STATUS, ena=1, count!=0: go to DATA; overflow <= 0.
  - STATUS, ena=1, count==0: stay in STATUS; overflow <= 0.
  - DATA, ena=1: pop. rd_ptr increments mod DEPTH; go to STATUS.
  - ena=0: no phase change.
- Overflow set and clear in the same cycle (dropped push during a STATUS-phase ena): set wins, overflow=1.
- Count update:
  - accepted push and pop in the same cycle: count unchanged
  - accepted push only: count+1
  - pop only: count-1
  - count never exceeds DEPTH and never goes below 0; pop is only possible in DATA, and DATA is only entered with count!=0
- Head stability: the head word is stable throughout DATA, since no pop occurs before exit. Pushes during DATA write only to the tail.
- Pointer wrap-around: pointers are AW bits and wrap naturally. Full and empty are distinguished solely by count.
- Latency:
  - pushed word is visible in the count/status word one cycle after the push edge
  - an empty FIFO shows the pushed word as head in the DATA phase following the next STATUS access
- ena held high across multiple cycles: each posedge is a separate access, so phase toggles every cycle (STATUS->DATA->STATUS with pop). The CPU issues ena for single-cycle pulses.

Test Plan:
1. Reset, then idle with ena=0 -> io=8'h00, Din_ready=1, count=0, overflow=0; one ena pulse -> reading stays 0.
2. Push 8'hA5 (N=8, DEPTH=4) -> next cycle status io=8'h81. First ena -> io=8'hA5. Second ena -> count=0 and status io=8'h00.
3. Push 8'h01,02,03,04,05 on consecutive cycles:
   - after 04: Din_ready=0
   - 05 dropped: count=4, overflow=1, status=8'hC4
   - next STATUS ena: overflow=0
   - four read pairs return 01,02,03,04 in order
4. FIFO holds 3 words and is in DATA phase. Assert Din_arrived with ena on the same edge -> pop and push both occur, count stays 3; FIFO order is preserved across the rd_ptr/wr_ptr wrap.
5. FIFO full, in DATA phase. Din_arrived=1 together with ena -> pop occurs, push dropped, count=3, overflow=1.
6. Two words queued, in DATA phase. Assert Reset for one cycle -> count=0, reading=0, overflow=0, status io=8'h00. Prior data is never returned.
